// File: rtl/uart_rx_fifo.sv
// Receive buffer between the buart holding register and the CPU read path.
// A three-state drain FSM pops buart into a first-word-fall-through FIFO.
module uart_rx_fifo #(
    parameter int unsigned DEPTH_LOG2 = 4,
    parameter int unsigned RTS_MARGIN = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  uart_valid,
    input  logic [7:0]            uart_data,
    output logic                  uart_rd,
    input  logic                  cpu_rd,
    output logic [7:0]            cpu_data,
    output logic                  cpu_valid,
    output logic [DEPTH_LOG2:0]   level,
    output logic                  full,
    output logic                  rx_ready,
    output logic                  overrun,
    input  logic                  clr_overrun
);

    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
    localparam int unsigned LVL_W = DEPTH_LOG2 + 1;

    typedef enum logic [1:0] {IDLE, POP, GUARD} state_t;

    state_t                state_q, state_d;
    logic                  uart_rd_q, uart_rd_d;
    logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]      level_q, level_d;
    logic                  overrun_q, overrun_d;
    logic [7:0]            mem_q [DEPTH];

    logic fifo_full, fifo_empty, push, pop, drop;

    assign fifo_full  = (level_q == LVL_W'(DEPTH));
    assign fifo_empty = (level_q == '0);

    always_comb begin
        state_d   = state_q;
        uart_rd_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (uart_valid) begin
                    state_d   = POP;
                    uart_rd_d = 1'b1;
                end
            end
            POP:     state_d = GUARD;
            GUARD:   state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // A pop in the same cycle frees a slot, so a full FIFO can still accept
        pop  = cpu_rd && !fifo_empty;
        push = (state_q == POP) && (!fifo_full || pop);
        drop = (state_q == POP) && fifo_full && !pop;

        wr_ptr_d = push ? wr_ptr_q + DEPTH_LOG2'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + DEPTH_LOG2'(1) : rd_ptr_q;

        level_d = level_q;
        case ({push, pop})
            2'b10:   level_d = level_q + LVL_W'(1);
            2'b01:   level_d = level_q - LVL_W'(1);
            default: level_d = level_q;
        endcase

        overrun_d = overrun_q;
        if (drop) begin
            overrun_d = 1'b1;
        end else if (clr_overrun) begin
            overrun_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            uart_rd_q <= 1'b0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            level_q   <= '0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            uart_rd_q <= uart_rd_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            level_q   <= level_d;
            overrun_q <= overrun_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && push) begin
            mem_q[wr_ptr_q] <= uart_data;
        end
    end

    assign uart_rd   = uart_rd_q;
    assign cpu_valid = !fifo_empty;
    assign cpu_data  = fifo_empty ? '0 : mem_q[rd_ptr_q];
    assign level     = level_q;
    assign full      = fifo_full;
    assign rx_ready  = (level_q <= LVL_W'(DEPTH - RTS_MARGIN));
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Scoreboard bench for uart_rx_fifo: a queue models FIFO contents and flags.
module tb_uart_rx_fifo;

    logic       clk = 1'b0;
    logic       rst;
    logic       uart_valid;
    logic [7:0] uart_data;
    logic       uart_rd;
    logic       cpu_rd;
    logic [7:0] cpu_data;
    logic       cpu_valid;
    logic [4:0] level;
    logic       full;
    logic       rx_ready;
    logic       overrun;
    logic       clr_overrun;

    int         checks = 0;
    int         errors = 0;
    logic [7:0] sb[$];
    logic       exp_overrun = 1'b0;

    uart_rx_fifo #(.DEPTH_LOG2(4), .RTS_MARGIN(4)) dut (
        .clk(clk), .rst(rst), .uart_valid(uart_valid), .uart_data(uart_data),
        .uart_rd(uart_rd), .cpu_rd(cpu_rd), .cpu_data(cpu_data),
        .cpu_valid(cpu_valid), .level(level), .full(full), .rx_ready(rx_ready),
        .overrun(overrun), .clr_overrun(clr_overrun)
    );

    always #5 clk = ~clk;

    // Inputs change and outputs are sampled on negedge, away from the active edge.
    task automatic send_byte(input logic [7:0] b, input bit pop_with, input bit clr_with);
        bit         seen;
        int         lat;
        bit         was_full;
        logic [7:0] exp;
        seen = 0;
        lat  = 0;
        uart_valid = 1'b1;
        uart_data  = b;
        for (int k = 1; k <= 6 && !seen; k++) begin
            @(negedge clk);
            if (uart_rd === 1'b1) begin
                seen = 1;
                lat  = k;
            end
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL pop_timeout: uart_rd never rose for byte %h", b);
            uart_valid = 1'b0;
            return;
        end
        checks++;
        if (lat !== 1) begin
            errors++;
            $display("FAIL pop_latency: got %0d cycles, expected 1", lat);
        end
        was_full = (sb.size() == 16);
        if (pop_with) begin
            cpu_rd = 1'b1;
            if (sb.size() > 0) begin
                exp = sb.pop_front();
                checks++;
                if (cpu_data !== exp) begin
                    errors++;
                    $display("FAIL pop_during_push_data: got %h expected %h", cpu_data, exp);
                end
            end
        end
        if (clr_with) clr_overrun = 1'b1;
        if (!was_full || pop_with) begin
            sb.push_back(b);
            if (clr_with) exp_overrun = 1'b0;
        end else begin
            exp_overrun = 1'b1;
        end
        @(negedge clk);
        cpu_rd      = 1'b0;
        clr_overrun = 1'b0;
        uart_valid  = 1'b0;
        checks++;
        if (uart_rd !== 1'b0) begin
            errors++;
            $display("FAIL pop_width: uart_rd got %b expected 0", uart_rd);
        end
        checks++;
        if (overrun !== exp_overrun) begin
            errors++;
            $display("FAIL push_overrun: got %b expected %b", overrun, exp_overrun);
        end
        checks++;
        if (level !== 5'(sb.size())) begin
            errors++;
            $display("FAIL push_level: got %0d expected %0d", level, sb.size());
        end
        @(negedge clk);
        checks++;
        if (uart_rd !== 1'b0) begin
            errors++;
            $display("FAIL repop: uart_rd got %b expected 0", uart_rd);
        end
    endtask

    task automatic read_one(output logic [7:0] got);
        logic [7:0] exp;
        got = cpu_data;
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $display("FAIL read_model_empty: got %h expected no read", cpu_data);
            return;
        end
        exp = sb.pop_front();
        if (cpu_data !== exp || cpu_valid !== 1'b1) begin
            errors++;
            $display("FAIL read_data: got %h/v%b expected %h/v1", cpu_data, cpu_valid, exp);
        end
        cpu_rd = 1'b1;
        @(negedge clk);
        cpu_rd = 1'b0;
        checks++;
        if (level !== 5'(sb.size())) begin
            errors++;
            $display("FAIL read_level: got %0d expected %0d", level, sb.size());
        end
        checks++;
        if (rx_ready !== ((16 - sb.size()) >= 4)) begin
            errors++;
            $display("FAIL read_rx_ready: got %b at level %0d", rx_ready, sb.size());
        end
        checks++;
        if (cpu_valid !== (sb.size() != 0)) begin
            errors++;
            $display("FAIL read_valid: got %b expected %b", cpu_valid, sb.size() != 0);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        sb.delete();
        exp_overrun = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (uart_rd !== 1'b0 || cpu_valid !== 1'b0 || cpu_data !== 8'h00 || level !== 5'd0 ||
            full !== 1'b0 || overrun !== 1'b0 || rx_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_state: got rd%b v%b d%h l%0d f%b o%b r%b expected rd0 v0 d00 l0 f0 o0 r1",
                     uart_rd, cpu_valid, cpu_data, level, full, overrun, rx_ready);
        end
    endtask

    task automatic test_single_byte();
        logic [7:0] got;
        send_byte(8'h41, 0, 0);
        checks++;
        if (cpu_valid !== 1'b1 || cpu_data !== 8'h41 || level !== 5'd1) begin
            errors++;
            $display("FAIL single_head: got v%b d%h l%0d expected v1 d41 l1", cpu_valid, cpu_data, level);
        end
        read_one(got);
        checks++;
        if (cpu_data !== 8'h00) begin
            errors++;
            $display("FAIL single_empty_data: got %h expected 00", cpu_data);
        end
    endtask

    task automatic test_fill_flow();
        for (int i = 0; i < 16; i++) begin
            send_byte(8'(i), 0, 0);
            checks++;
            if (rx_ready !== (i + 1 <= 12) || full !== (i == 15)) begin
                errors++;
                $display("FAIL fill_flags: level %0d got r%b f%b expected r%b f%b",
                         i + 1, rx_ready, full, (i + 1 <= 12), (i == 15));
            end
        end
    endtask

    task automatic test_overrun();
        send_byte(8'h55, 0, 0);
        checks++;
        if (overrun !== 1'b1 || level !== 5'd16 || cpu_data !== 8'h00) begin
            errors++;
            $display("FAIL overrun_drop: got o%b l%0d d%h expected o1 l16 d00", overrun, level, cpu_data);
        end
        // A drop coinciding with clr_overrun must leave the flag set.
        send_byte(8'h56, 0, 1);
        clr_overrun = 1'b1;
        @(negedge clk);
        clr_overrun = 1'b0;
        exp_overrun = 1'b0;
        checks++;
        if (overrun !== 1'b0) begin
            errors++;
            $display("FAIL overrun_clear: got %b expected 0", overrun);
        end
    endtask

    task automatic test_full_simul_pop();
        logic [7:0] got;
        send_byte(8'h77, 1, 0);
        checks++;
        if (overrun !== 1'b0 || level !== 5'd16) begin
            errors++;
            $display("FAIL full_pop_push: got o%b l%0d expected o0 l16", overrun, level);
        end
        got = 8'h00;
        for (int i = 0; i < 16; i++) read_one(got);
        checks++;
        if (got !== 8'h77) begin
            errors++;
            $display("FAIL full_pop_last: got %h expected 77", got);
        end
    endtask

    task automatic test_wrap();
        logic [7:0] got;
        for (int i = 0; i < 40; i++) begin
            send_byte(8'($urandom_range(0, 255)), 0, 0);
            if (i % 3 != 0) read_one(got);
        end
        while (sb.size() > 0) read_one(got);
    endtask

    task automatic test_empty_read();
        logic [7:0] got;
        cpu_rd = 1'b1;
        @(negedge clk);
        cpu_rd = 1'b0;
        checks++;
        if (level !== 5'd0 || cpu_valid !== 1'b0 || cpu_data !== 8'h00) begin
            errors++;
            $display("FAIL empty_read: got l%0d v%b d%h expected l0 v0 d00", level, cpu_valid, cpu_data);
        end
        send_byte(8'h3C, 0, 0);
        read_one(got);
    endtask

    task automatic test_reset_mid();
        bit seen;
        for (int i = 0; i < 5; i++) send_byte(8'hC0 + 8'(i), 0, 0);
        uart_valid = 1'b1;
        uart_data  = 8'hEE;
        seen = 0;
        for (int k = 0; k < 6 && !seen; k++) begin
            @(negedge clk);
            if (uart_rd === 1'b1) seen = 1;
        end
        checks++;
        if (!seen || level !== 5'd5) begin
            errors++;
            $display("FAIL reset_mid_setup: got seen%b l%0d expected seen1 l5", seen, level);
        end
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (uart_rd !== 1'b0 || level !== 5'd0 || cpu_valid !== 1'b0 || overrun !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_state: got rd%b l%0d v%b o%b expected rd0 l0 v0 o0",
                     uart_rd, level, cpu_valid, overrun);
        end
        rst        = 1'b0;
        uart_valid = 1'b0;
        sb.delete();
        exp_overrun = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (level !== 5'd0 || uart_rd !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_inflight: got l%0d rd%b expected l0 rd0", level, uart_rd);
        end
        test_empty_read();
    endtask

    initial begin
        rst = 1'b1;
        uart_valid = 1'b0;
        uart_data = 8'h00;
        cpu_rd = 1'b0;
        clr_overrun = 1'b0;
        test_reset();
        test_single_byte();
        test_fill_flow();
        test_overrun();
        test_full_simul_pop();
        test_wrap();
        test_empty_read();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
